// File: rtl/servo_cmd_ctrl.sv
// servo_cmd_ctrl: parses {CMD, US_HI, US_LO, 0x0A} frames from the UART receiver,
// drives the servo pulse width in clock cycles, and returns a 4-byte status reply
// {STATUS, US_HI, US_LO, 0x0A} through the UART transmitter handshake.
module servo_cmd_ctrl #(
    parameter int CLK_MHZ     = 27,
    parameter int MIN_US      = 500,
    parameter int MAX_US      = 2500,
    parameter int DEFAULT_US  = 1500,
    parameter int TIMEOUT_CYC = 2700000,
    parameter int WIDTH_W     = 24
) (
    input  logic               i_clk,
    input  logic               i_resetn,
    input  logic               i_rx_valid,
    input  logic [7:0]         i_rx_data,
    input  logic               i_tx_busy,
    output logic               o_tx_en,
    output logic [7:0]         o_tx_data,
    output logic [WIDTH_W-1:0] o_pwm_width,
    output logic [15:0]        o_pwm_us,
    output logic               o_frame_err,
    output logic               o_overrun
);

    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] CMD_SET  = 8'h53;
    localparam logic [7:0] CMD_QRY  = 8'h3F;
    localparam logic [7:0] ST_ACK   = 8'h41;
    localparam logic [7:0] ST_CLAMP = 8'h43;
    localparam logic [7:0] ST_NAK   = 8'h4E;
    localparam int         TO_W     = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {R_CMD, R_HI, R_LO, R_TERM} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAITB, T_WAITI} tx_state_t;

    function automatic logic [15:0] clamp_us(input logic [15:0] us);
        if (us < 16'(MIN_US)) return 16'(MIN_US);
        if (us > 16'(MAX_US)) return 16'(MAX_US);
        return us;
    endfunction

    // Product is formed at 32 bits, then fitted to the output width.
    function automatic logic [WIDTH_W-1:0] to_cycles(input logic [15:0] us);
        logic [31:0] prod;
        prod = {16'd0, us} * 32'(CLK_MHZ);
        return prod[WIDTH_W-1:0];
    endfunction

    rx_state_t       rx_state, rx_next;
    tx_state_t       tx_state, tx_next;
    logic [7:0]      cmd_q, hi_q, lo_q;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit, timeout, frame_done;
    logic            term_ok, dec_upd;
    logic [15:0]     req_us, req_clamped, dec_us;
    logic [7:0]      dec_status;
    logic            slot_full;
    logic [7:0]      slot_status;
    logic [15:0]     slot_us;
    logic            tx_load, tx_adv;
    logic [1:0]      tx_idx, wb_cnt;
    logic [31:0]     tx_sh;

    assign to_hit    = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign o_tx_data = tx_sh[31:24];

    // RX next state: advance on each byte strobe, fall back to R_CMD on inter-byte timeout.
    always_comb begin
        rx_next    = rx_state;
        frame_done = 1'b0;
        timeout    = 1'b0;
        case (rx_state)
            R_CMD:  if (i_rx_valid && i_rx_data != LF) rx_next = R_HI;
            R_HI:   if (i_rx_valid) rx_next = R_LO;
                    else if (to_hit) begin rx_next = R_CMD; timeout = 1'b1; end
            R_LO:   if (i_rx_valid) rx_next = R_TERM;
                    else if (to_hit) begin rx_next = R_CMD; timeout = 1'b1; end
            R_TERM: if (i_rx_valid) begin rx_next = R_CMD; frame_done = 1'b1; end
                    else if (to_hit) begin rx_next = R_CMD; timeout = 1'b1; end
            default: rx_next = R_CMD;
        endcase
    end

    // Frame decode: status and reply pulse width, evaluated on the terminator byte.
    always_comb begin
        req_us      = {hi_q, lo_q};
        req_clamped = clamp_us(req_us);
        term_ok     = (i_rx_data == LF);
        dec_us      = o_pwm_us;
        dec_status  = ST_NAK;
        dec_upd     = 1'b0;
        if (term_ok) begin
            if (cmd_q == CMD_SET) begin
                dec_us     = req_clamped;
                dec_upd    = 1'b1;
                dec_status = (req_clamped != req_us) ? ST_CLAMP : ST_ACK;
            end else if (cmd_q == CMD_QRY) begin
                dec_status = ST_ACK;
            end
        end
    end

    // RX state, field capture, timeout counter, pulse-width outputs and the reply slot.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            rx_state    <= R_CMD;
            cmd_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            to_cnt      <= '0;
            o_pwm_us    <= 16'(DEFAULT_US);
            o_pwm_width <= to_cycles(16'(DEFAULT_US));
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            slot_full   <= 1'b0;
            slot_status <= '0;
            slot_us     <= '0;
        end else begin
            rx_state    <= rx_next;
            o_frame_err <= timeout | (frame_done & ~term_ok);
            o_overrun   <= 1'b0;
            if (i_rx_valid) begin
                case (rx_state)
                    R_CMD:   cmd_q <= i_rx_data;
                    R_HI:    hi_q  <= i_rx_data;
                    R_LO:    lo_q  <= i_rx_data;
                    default: ;
                endcase
            end
            if (i_rx_valid || rx_state == R_CMD || timeout) to_cnt <= '0;
            else                                             to_cnt <= to_cnt + 1'b1;
            if (frame_done && dec_upd) begin
                o_pwm_us    <= dec_us;
                o_pwm_width <= to_cycles(dec_us);
            end
            // A slot being handed to TX this cycle counts as free for the new reply.
            if (frame_done) begin
                if (slot_full && !tx_load) begin
                    o_overrun <= 1'b1;
                end else begin
                    slot_full   <= 1'b1;
                    slot_status <= dec_status;
                    slot_us     <= dec_us;
                end
            end else if (tx_load) begin
                slot_full <= 1'b0;
            end
        end
    end

    // TX next state and strobe; the strobe is withheld whenever the transmitter is busy.
    always_comb begin
        tx_next = tx_state;
        o_tx_en = 1'b0;
        tx_load = 1'b0;
        tx_adv  = 1'b0;
        case (tx_state)
            T_IDLE:  if (slot_full && !i_tx_busy) begin tx_load = 1'b1; tx_next = T_SEND; end
            T_SEND:  if (!i_tx_busy) begin o_tx_en = 1'b1; tx_next = T_WAITB; end
            T_WAITB: if (i_tx_busy || wb_cnt == 2'd3) tx_next = T_WAITI;
            T_WAITI: if (!i_tx_busy) begin
                         if (tx_idx == 2'd3) tx_next = T_IDLE;
                         else begin tx_adv = 1'b1; tx_next = T_SEND; end
                     end
            default: tx_next = T_IDLE;
        endcase
    end

    // TX state, busy-wait counter and reply byte shifter.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            tx_state <= T_IDLE;
            wb_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
        end else begin
            tx_state <= tx_next;
            wb_cnt   <= (tx_state == T_WAITB) ? wb_cnt + 1'b1 : 2'd0;
            if (tx_load) begin
                tx_sh  <= {slot_status, slot_us, LF};
                tx_idx <= '0;
            end else if (tx_adv) begin
                tx_sh  <= {tx_sh[23:0], 8'h00};
                tx_idx <= tx_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_servo_cmd_ctrl.sv
// Directed bench for servo_cmd_ctrl with a reply scoreboard and a uart_tx busy model.
module tb_servo_cmd_ctrl;

    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_busy;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic [23:0] pwm_width;
    logic [15:0] pwm_us;
    logic        frame_err;
    logic        overrun;

    int checks   = 0;
    int failures = 0;
    int tx_count = 0;
    int busy_cnt = 0;
    bit pend     = 1'b0;
    bit force_busy = 1'b0;
    logic [7:0] exp_q[$];

    servo_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .i_clk(clk), .i_resetn(resetn), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .i_tx_busy(tx_busy), .o_tx_en(tx_en), .o_tx_data(tx_data),
        .o_pwm_width(pwm_width), .o_pwm_us(pwm_us), .o_frame_err(frame_err),
        .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] t);
        send_byte(c);
        send_byte(h);
        send_byte(l);
        send_byte(t);
    endtask

    task automatic expect_reply(input logic [7:0] st, input logic [15:0] us);
        exp_q.push_back(st);
        exp_q.push_back(us[15:8]);
        exp_q.push_back(us[7:0]);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk(tag, exp_q.size(), 0);
    endtask

    // uart_tx model: busy rises the cycle after a strobe is taken and holds 5 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (pend) begin busy_cnt = 5; pend = 1'b0; end
            tx_busy = force_busy || (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            if (tx_en === 1'b1) begin
                chk("tx_en_while_busy", tx_busy, 0);
                chk("tx_reply_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("tx_byte", tx_data, exp_q.pop_front());
                tx_count++;
                pend = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state, and no spontaneous TX traffic.
        chk("rst_pwm_us", pwm_us, 1500);
        chk("rst_pwm_width", pwm_width, 40500);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        repeat (20) @(posedge clk);

        // Set 1500 us.
        expect_reply(8'h41, 16'd1500);
        send_frame(8'h53, 8'h05, 8'hDC, 8'h0A);
        chk("set1500_width", pwm_width, 40500);
        chk("set1500_us", pwm_us, 1500);
        wait_drain("set1500_drain");

        // Leading LF ignored, exact upper bound accepted unclamped.
        expect_reply(8'h41, 16'd2500);
        send_byte(8'h0A);
        send_frame(8'h53, 8'h09, 8'hC4, 8'h0A);
        chk("set2500_width", pwm_width, 67500);
        chk("set2500_us", pwm_us, 2500);
        wait_drain("set2500_drain");

        // Above MAX clamps to 2500.
        expect_reply(8'h43, 16'd2500);
        send_frame(8'h53, 8'hFF, 8'hFF, 8'h0A);
        chk("clamp_hi_width", pwm_width, 67500);
        wait_drain("clamp_hi_drain");

        // Below MIN clamps to 500; width visible right after the terminator edge.
        expect_reply(8'h43, 16'd500);
        send_frame(8'h53, 8'h00, 8'h64, 8'h0A);
        chk("clamp_lo_width", pwm_width, 13500);
        chk("clamp_lo_us", pwm_us, 500);
        chk("clamp_lo_no_err", frame_err, 0);
        wait_drain("clamp_lo_drain");

        // Bad terminator: NAK with current width, error pulse, no update.
        expect_reply(8'h4E, 16'd500);
        send_frame(8'h53, 8'h07, 8'hD0, 8'h55);
        chk("badterm_err", frame_err, 1);
        chk("badterm_width", pwm_width, 13500);
        @(posedge clk); #1;
        chk("badterm_err_pulse", frame_err, 0);
        wait_drain("badterm_drain");

        // Inter-byte timeout: error pulse after exactly TO idle cycles, no reply.
        send_byte(8'h53);
        send_byte(8'h07);
        n = 0;
        while (frame_err !== 1'b1 && n < 3 * TO) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_cycles", n, TO);
        chk("timeout_us", pwm_us, 500);
        repeat (30) @(posedge clk);

        // Query after timeout.
        expect_reply(8'h41, 16'd500);
        send_frame(8'h3F, 8'h00, 8'h00, 8'h0A);
        wait_drain("query_drain");

        // Unknown command.
        expect_reply(8'h4E, 16'd500);
        send_frame(8'h58, 8'h05, 8'hDC, 8'h0A);
        chk("unknown_us", pwm_us, 500);
        wait_drain("unknown_drain");

        // Two queries while busy: second reply dropped with an overrun pulse.
        force_busy = 1'b1;
        expect_reply(8'h41, 16'd500);
        send_frame(8'h3F, 8'h00, 8'h00, 8'h0A);
        chk("ovr_first_none", overrun, 0);
        send_frame(8'h3F, 8'h00, 8'h00, 8'h0A);
        chk("ovr_pulse", overrun, 1);
        @(posedge clk); #1;
        chk("ovr_pulse_end", overrun, 0);
        base = tx_count;
        force_busy = 1'b0;

        // Reset in the middle of the reply aborts it.
        n = 0;
        while (tx_count < base + 2 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midreply_reached", tx_count >= base + 2, 1);
        resetn = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_tx_en", tx_en, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        chk("rst2_pwm_us", pwm_us, 1500);
        chk("rst2_tx_data", tx_data, 0);
        base = tx_count;
        repeat (100) @(posedge clk);
        #1;
        chk("rst2_no_tx", tx_count, base);

        // New frame after reset replies normally.
        expect_reply(8'h41, 16'd1500);
        send_frame(8'h3F, 8'h00, 8'h00, 8'h0A);
        wait_drain("post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
